pipelined_control_unit: RTL and testbench

- Next-generation main control for the 5-stage RISC-V pipeline.
- Decodes the ID-stage opcode and carries the control bits through registered ID/EX, EX/MEM and MEM/WB control stages.
- Detects load-use hazards and stalls by inserting bubbles; handles branch flushes.
- Counts stall cycles for performance monitoring. Sits between the IF/ID register and the datapath stage registers.

---
 rtl/pipelined_control_unit.sv | 212 +++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// Main control for a 5-stage RISC-V pipeline: ID decode, ID/EX -> EX/MEM -> MEM/WB control
// stages, load-use stall and branch flush. Optional jump/upper-immediate decode under JUMP_DECODE_EN.
module pipelined_control_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  ex_ALUSrc,
    output logic                  ex_Branch,
    output logic                  ex_MemRead,
    output logic                  ex_MemWrite,
    output logic                  ex_RegWrite,
    output logic                  ex_MemtoReg,
    output logic                  ex_Jump,
    output logic [ALUOP_W-1:0]    ex_ALUop,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_Branch,
    output logic                  mem_MemRead,
    output logic                  mem_MemWrite,
    output logic                  mem_RegWrite,
    output logic                  mem_MemtoReg,
    output logic                  mem_Jump,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_RegWrite,
    output logic                  wb_MemtoReg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [CNT_W-1:0]      stall_count
);

    typedef struct packed {
        logic               alu_src;
        logic               branch;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
        logic               jump;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    ctrl_t                 w_ctrl;
    logic                  w_uses_rs1;
    logic                  w_uses_rs2;
    logic                  w_hazard;
    logic                  w_stall;

    ctrl_t                 r_ex;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_mem_branch;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_mem_reg_write;
    logic                  r_mem_to_reg;
    logic                  r_mem_jump;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_wb_reg_write;
    logic                  r_wb_to_reg;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [CNT_W-1:0]      r_stall_cnt;

    always_comb begin
        w_ctrl     = '0;
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        case (opcode)
            7'b0110011: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_W'(2'b10);
                w_uses_rs1       = 1'b1;
                w_uses_rs2       = 1'b1;
            end
            7'b0010011: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_W'(2'b10);
                w_uses_rs1       = 1'b1;
            end
            7'b0000011: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_uses_rs1        = 1'b1;
            end
            7'b0100011: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_uses_rs1       = 1'b1;
                w_uses_rs2       = 1'b1;
            end
            7'b1100011: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.alu_op = ALUOP_W'(2'b01);
                w_uses_rs1    = 1'b1;
                w_uses_rs2    = 1'b1;
            end
`ifdef JUMP_DECODE_EN
            7'b1101111: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.jump      = 1'b1;
            end
            7'b1100111: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_uses_rs1       = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // rd==0 in EX (x0 or a bubble) can never produce a load-use dependency
    assign w_hazard = r_ex.mem_read && (r_ex_rd != '0) &&
                      ((w_uses_rs1 && (r_ex_rd == id_rs1)) ||
                       (w_uses_rs2 && (r_ex_rd == id_rs2)));
    assign w_stall  = w_hazard && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex            <= '0;
            r_ex_rd         <= '0;
            r_mem_branch    <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_reg_write <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_mem_jump      <= 1'b0;
            r_mem_rd        <= '0;
            r_wb_reg_write  <= 1'b0;
            r_wb_to_reg     <= 1'b0;
            r_wb_rd         <= '0;
            r_stall_cnt     <= '0;
        end else begin
            r_wb_reg_write <= r_mem_reg_write;
            r_wb_to_reg    <= r_mem_to_reg;
            r_wb_rd        <= r_mem_rd;

            if (flush) begin
                r_mem_branch    <= 1'b0;
                r_mem_read      <= 1'b0;
                r_mem_write     <= 1'b0;
                r_mem_reg_write <= 1'b0;
                r_mem_to_reg    <= 1'b0;
                r_mem_jump      <= 1'b0;
                r_mem_rd        <= '0;
            end else begin
                r_mem_branch    <= r_ex.branch;
                r_mem_read      <= r_ex.mem_read;
                r_mem_write     <= r_ex.mem_write;
                r_mem_reg_write <= r_ex.reg_write;
                r_mem_to_reg    <= r_ex.mem_to_reg;
                r_mem_jump      <= r_ex.jump;
                r_mem_rd        <= r_ex_rd;
            end

            if (flush || w_hazard) begin
                r_ex    <= '0;
                r_ex_rd <= '0;
            end else begin
                r_ex    <= w_ctrl;
                r_ex_rd <= id_rd;
            end

            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign pc_write     = !w_hazard || flush;
    assign ifid_write   = !w_hazard || flush;
    assign ifid_flush   = flush;

    assign ex_ALUSrc    = r_ex.alu_src;
    assign ex_Branch    = r_ex.branch;
    assign ex_MemRead   = r_ex.mem_read;
    assign ex_MemWrite  = r_ex.mem_write;
    assign ex_RegWrite  = r_ex.reg_write;
    assign ex_MemtoReg  = r_ex.mem_to_reg;
    assign ex_Jump      = r_ex.jump;
    assign ex_ALUop     = r_ex.alu_op;
    assign ex_rd        = r_ex_rd;

    assign mem_Branch   = r_mem_branch;
    assign mem_MemRead  = r_mem_read;
    assign mem_MemWrite = r_mem_write;
    assign mem_RegWrite = r_mem_reg_write;
    assign mem_MemtoReg = r_mem_to_reg;
    assign mem_Jump     = r_mem_jump;
    assign mem_rd       = r_mem_rd;

    assign wb_RegWrite  = r_wb_reg_write;
    assign wb_MemtoReg  = r_wb_to_reg;
    assign wb_rd        = r_wb_rd;

    assign stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed steps then random traffic against an in-bench model.
// A second instance with CNT_W=2 shares the inputs to exercise counter saturation.
module tb_pipelined_control_unit;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    logic       clk = 1'b0, clk_en = 1'b0, reset = 1'b0, flush = 1'b0;
    logic [6:0] opcode = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

    logic pc_write, ifid_write, ifid_flush;
    logic ex_ALUSrc, ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg, ex_Jump;
    logic [1:0] ex_ALUop;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic mem_Branch, mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg, mem_Jump;
    logic wb_RegWrite, wb_MemtoReg;
    logic [15:0] stall_count;

    logic pc_write_s, ifid_write_s, ifid_flush_s;
    logic ex_ALUSrc_s, ex_Branch_s, ex_MemRead_s, ex_MemWrite_s, ex_RegWrite_s, ex_MemtoReg_s, ex_Jump_s;
    logic [1:0] ex_ALUop_s;
    logic [4:0] ex_rd_s, mem_rd_s, wb_rd_s;
    logic mem_Branch_s, mem_MemRead_s, mem_MemWrite_s, mem_RegWrite_s, mem_MemtoReg_s, mem_Jump_s;
    logic wb_RegWrite_s, wb_MemtoReg_s;
    logic [1:0] stall_count_s;

    pipelined_control_unit #(.REG_ADDR_W(5), .ALUOP_W(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .flush(flush), .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .ex_Jump(ex_Jump), .ex_ALUop(ex_ALUop),
        .ex_rd(ex_rd), .mem_Branch(mem_Branch), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg), .mem_Jump(mem_Jump), .mem_rd(mem_rd),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_rd(wb_rd), .stall_count(stall_count)
    );

    pipelined_control_unit #(.REG_ADDR_W(5), .ALUOP_W(2), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .opcode(opcode), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .flush(flush), .pc_write(pc_write_s), .ifid_write(ifid_write_s), .ifid_flush(ifid_flush_s),
        .ex_ALUSrc(ex_ALUSrc_s), .ex_Branch(ex_Branch_s), .ex_MemRead(ex_MemRead_s),
        .ex_MemWrite(ex_MemWrite_s), .ex_RegWrite(ex_RegWrite_s), .ex_MemtoReg(ex_MemtoReg_s),
        .ex_Jump(ex_Jump_s), .ex_ALUop(ex_ALUop_s), .ex_rd(ex_rd_s), .mem_Branch(mem_Branch_s),
        .mem_MemRead(mem_MemRead_s), .mem_MemWrite(mem_MemWrite_s), .mem_RegWrite(mem_RegWrite_s),
        .mem_MemtoReg(mem_MemtoReg_s), .mem_Jump(mem_Jump_s), .mem_rd(mem_rd_s),
        .wb_RegWrite(wb_RegWrite_s), .wb_MemtoReg(wb_MemtoReg_s), .wb_rd(wb_rd_s),
        .stall_count(stall_count_s)
    );

    always #5 if (clk_en) clk = ~clk;

    typedef struct packed {
        logic alusrc, branch, memread, memwrite, regwrite, memtoreg, jump;
        logic [1:0] aluop;
        logic [4:0] rd;
        logic u1, u2;
    } rec_t;

    rec_t mex, mmem, mwb;
    int   cnt, cnt_s;
    int   tests = 0, fails = 0;

    function automatic rec_t dec(input logic [6:0] op, input logic [4:0] rd);
        rec_t r;
        r = '0;
        r.rd = rd;
        case (op)
            OP_R:  begin r.regwrite = 1; r.aluop = 2'b10; r.u1 = 1; r.u2 = 1; end
            OP_I:  begin r.alusrc = 1; r.regwrite = 1; r.aluop = 2'b10; r.u1 = 1; end
            OP_LD: begin r.alusrc = 1; r.memtoreg = 1; r.regwrite = 1; r.memread = 1; r.u1 = 1; end
            OP_ST: begin r.alusrc = 1; r.memwrite = 1; r.u1 = 1; r.u2 = 1; end
            OP_BR: begin r.branch = 1; r.aluop = 2'b01; r.u1 = 1; r.u2 = 1; end
`ifdef JUMP_DECODE_EN
            OP_JAL:  begin r.regwrite = 1; r.jump = 1; end
            OP_JALR: begin r.alusrc = 1; r.regwrite = 1; r.jump = 1; r.u1 = 1; end
            OP_LUI, OP_AUIPC: begin r.alusrc = 1; r.regwrite = 1; end
`endif
            default: ;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_regs();
        chk("ex_ctrl", {ex_ALUSrc, ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg,
                        ex_Jump, ex_ALUop, ex_rd},
            {mex.alusrc, mex.branch, mex.memread, mex.memwrite, mex.regwrite, mex.memtoreg,
             mex.jump, mex.aluop, mex.rd});
        chk("mem_ctrl", {mem_Branch, mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg, mem_Jump, mem_rd},
            {mmem.branch, mmem.memread, mmem.memwrite, mmem.regwrite, mmem.memtoreg, mmem.jump, mmem.rd});
        chk("wb_ctrl", {wb_RegWrite, wb_MemtoReg, wb_rd}, {mwb.regwrite, mwb.memtoreg, mwb.rd});
        chk("ex_ctrl_sat", {ex_MemRead_s, ex_RegWrite_s, ex_rd_s}, {mex.memread, mex.regwrite, mex.rd});
        chk("stall_count", 32'(stall_count), 32'(cnt));
        chk("stall_count_sat", 32'(stall_count_s), 32'(cnt_s));
    endtask

    // One cycle: present ID inputs, check combinational controls, clock, check stage registers.
    task automatic step(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic fl);
        rec_t d;
        logic hz;
        opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; flush = fl;
        #1;
        d  = dec(op, rd);
        hz = mex.memread && (mex.rd != 0) &&
             ((d.u1 && mex.rd == rs1) || (d.u2 && mex.rd == rs2));
        chk("pc_write", 32'(pc_write), 32'(!hz || fl));
        chk("ifid_write", 32'(ifid_write), 32'(!hz || fl));
        chk("ifid_flush", 32'(ifid_flush), 32'(fl));
        chk("pc_write_sat", 32'(pc_write_s), 32'(!hz || fl));
        @(posedge clk);
        mwb  = mmem;
        mmem = fl ? '0 : mex;
        mex  = (fl || hz) ? '0 : d;
        if (hz && !fl) begin
            if (cnt < 65535) cnt++;
            if (cnt_s < 3) cnt_s++;
        end
        #1;
        check_regs();
    endtask

    logic [6:0] ops [12];

    initial begin
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
                7'b0000000, 7'b1111111, 7'b0001111};
        mex = '0; mmem = '0; mwb = '0; cnt = 0; cnt_s = 0;

        // Reset with the clock stopped
        #2 reset = 1'b1;
        #1;
        check_regs();
        chk("reset_pc_write", 32'(pc_write), 32'd1);
        chk("reset_ifid_flush", 32'(ifid_flush), 32'd0);
        reset = 1'b0;
        clk_en = 1'b1;

        // R-type walks through EX, MEM, WB
        step(OP_R, 1, 2, 3, 0);
        chk("r_ex_regwrite", {30'd0, ex_RegWrite, ex_ALUop[1]}, 32'd3);
        step(7'b0000000, 0, 0, 0, 0);
        step(7'b0000000, 0, 0, 0, 0);
        chk("r_wb_regwrite", 32'(wb_RegWrite), 32'd1);

        // Decode sweep
        foreach (ops[k]) step(ops[k], 0, 0, 5'd7, 0);
        step(7'b1111111, 0, 0, 0, 0);

        // Load-use stall on rs2
        step(OP_LD, 1, 0, 5, 0);
        step(OP_R, 2, 5, 6, 0);
        chk("stall_ex_bubble", 32'({ex_RegWrite, ex_MemRead, ex_rd}), 32'd0);
        step(OP_R, 2, 5, 6, 0);
        chk("stall_once", 32'(stall_count), 32'd1);

        // No false hazards: x0 destination, and I-type's rs2 field is not a source
        step(OP_LD, 1, 0, 0, 0);
        step(OP_R, 0, 0, 4, 0);
        step(OP_LD, 1, 0, 5, 0);
        step(OP_I, 3, 5, 4, 0);
        chk("no_false_hazard", 32'(stall_count), 32'd1);

        // Back-to-back dependent loads each stall once
        step(OP_LD, 1, 0, 5, 0);
        step(OP_LD, 5, 0, 6, 0);
        step(OP_LD, 5, 0, 6, 0);
        step(OP_ST, 6, 6, 0, 0);
        step(OP_ST, 6, 6, 0, 0);

        // Flush overrides a concurrent hazard
        step(OP_LD, 1, 0, 5, 0);
        step(OP_R, 5, 0, 6, 1);
        chk("flush_ex_zero", 32'({ex_RegWrite, ex_rd}), 32'd0);

        // Saturation of the 2-bit counter
        for (int p = 0; p < 5; p++) begin
            step(OP_LD, 1, 0, 9, 0);
            step(OP_BR, 9, 2, 0, 0);
            step(OP_BR, 9, 2, 0, 0);
        end
        chk("sat_hold", 32'(stall_count_s), 32'd3);

`ifdef JUMP_DECODE_EN
        step(OP_JAL, 0, 0, 1, 0);
        chk("jal_ex", {30'd0, ex_Jump, ex_RegWrite}, 32'd3);
`endif

        // Asynchronous reset mid-operation, between clock edges
        step(OP_LD, 1, 0, 5, 0);
        reset = 1'b1;
        #1;
        mex = '0; mmem = '0; mwb = '0; cnt = 0; cnt_s = 0;
        check_regs();
        #1 reset = 1'b0;

        // Random traffic with small register indices to provoke hazards
        for (int n = 0; n < 400; n++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 5) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 2) == 0) op = OP_LD;
            step(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
